// File: rtl/lfsr_rand_draw_if.sv
// Handshake bundle between the game-control requester and the LFSR ranged-draw source.
interface lfsr_rand_draw_if #(
    parameter int WIDTH = 4,
    parameter int OUT_W = 4
);
    logic             en;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic             ready;
    logic             valid;
    logic [OUT_W-1:0] value;
    logic [WIDTH-1:0] lfsr_state;

    modport master (
        output en, seed_load, seed_in, req,
        input  ready, valid, value, lfsr_state
    );

    modport slave (
        input  en, seed_load, seed_in, req,
        output ready, valid, value, lfsr_state
    );
endinterface

// File: rtl/lfsr_rand_draw.sv
// Fibonacci LFSR with seed loading, lock-up recovery and a ranged-draw handshake.
// Optional macro RAND_NO_REPEAT_EN also rejects a candidate equal to the previous draw.
module lfsr_rand_draw #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] TAPS    = 4'h9,
    parameter logic [WIDTH-1:0] SEED    = 1,
    parameter int               OUT_W   = 4,
    parameter int               RANGE   = 9,
    parameter int               MAX_TRY = 8
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_rand_draw_if.slave   bus
);

    localparam int CMP_W = (OUT_W > $clog2(RANGE) + 1) ? OUT_W : $clog2(RANGE) + 1;
    localparam int TRY_W = $clog2(MAX_TRY + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DRAW = 1'b1;

    logic [0:0]       fsm_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_next;
    logic [OUT_W-1:0] value_q;
    logic [OUT_W-1:0] prev_q;
    logic             valid_q;
    logic [TRY_W-1:0] try_q;

    logic [OUT_W-1:0] cand;
    logic [CMP_W-1:0] cand_ext;
    logic [CMP_W-1:0] range_ext;
    logic [CMP_W-1:0] prev_inc;
    logic [OUT_W-1:0] fallback;
    logic             cand_ok;

    // A zero state would lock the register up, so it re-enters the sequence at SEED.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        if (s == '0)
            return SEED;
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    always_comb begin
        cand      = lfsr_q[OUT_W-1:0];
        cand_ext  = CMP_W'(cand);
        range_ext = CMP_W'(RANGE);
        prev_inc  = CMP_W'(prev_q) + CMP_W'(1);
        fallback  = (prev_inc == range_ext) ? '0 : prev_inc[OUT_W-1:0];
`ifdef RAND_NO_REPEAT_EN
        cand_ok   = (cand_ext < range_ext) && (cand != prev_q);
`else
        cand_ok   = (cand_ext < range_ext);
`endif
    end

    always_comb begin
        lfsr_next = lfsr_q;
        if (bus.seed_load)
            lfsr_next = (bus.seed_in == '0) ? SEED : bus.seed_in;
        else if ((fsm_q == S_DRAW) || bus.en)
            lfsr_next = lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            lfsr_q  <= SEED;
            value_q <= '0;
            prev_q  <= '0;
            valid_q <= 1'b0;
            try_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_next;
            valid_q <= 1'b0;
            case (fsm_q)
                S_IDLE: begin
                    if (bus.req) begin
                        fsm_q <= S_DRAW;
                        try_q <= '0;
                    end
                end
                default: begin
                    // prev tracks the delivered value (fallback included) so repeats are judged against it.
                    if (cand_ok) begin
                        value_q <= cand;
                        prev_q  <= cand;
                        valid_q <= 1'b1;
                        fsm_q   <= S_IDLE;
                    end else if (try_q == TRY_W'(MAX_TRY - 1)) begin
                        value_q <= fallback;
                        prev_q  <= fallback;
                        valid_q <= 1'b1;
                        fsm_q   <= S_IDLE;
                    end else begin
                        try_q <= try_q + TRY_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.ready      = (fsm_q == S_IDLE);
    assign bus.valid      = valid_q;
    assign bus.value      = value_q;
    assign bus.lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rand_draw.sv
// Directed bench for lfsr_rand_draw: free-run sequence, draws, fallback, lock-up, reset abort.
module tb_lfsr_rand_draw;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    lfsr_rand_draw_if #(.WIDTH(4), .OUT_W(4)) bus_a ();
    lfsr_rand_draw_if #(.WIDTH(4), .OUT_W(4)) bus_b ();

    lfsr_rand_draw #(.WIDTH(4), .TAPS(4'h9), .SEED(4'd1), .OUT_W(4), .RANGE(9), .MAX_TRY(8))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    lfsr_rand_draw #(.WIDTH(4), .TAPS(4'h9), .SEED(4'd1), .OUT_W(4), .RANGE(9), .MAX_TRY(2))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    initial begin
        #500us;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic load_seed(input bit use_b, input logic [3:0] s);
        if (use_b) begin bus_b.seed_load = 1'b1; bus_b.seed_in = s; end
        else       begin bus_a.seed_load = 1'b1; bus_a.seed_in = s; end
        @(negedge clk);
        bus_a.seed_load = 1'b0;
        bus_b.seed_load = 1'b0;
    endtask

    // Issues one request and waits (bounded) for valid; cyc counts edges after the accept edge.
    task automatic draw(input bit use_b, output int cyc, output logic [3:0] v,
                        output bit rdy_bad, output bit v_rdy);
        cyc = 0; v = 4'hx; rdy_bad = 1'b0; v_rdy = 1'b0;
        if (use_b) bus_b.req = 1'b1; else bus_a.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.req = 1'b0;
        bus_b.req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (use_b ? bus_b.ready : bus_a.ready) rdy_bad = 1'b1;
            @(negedge clk);
            cyc++;
            if (use_b ? bus_b.valid : bus_a.valid) begin
                v     = use_b ? bus_b.value : bus_a.value;
                v_rdy = use_b ? bus_b.ready : bus_a.ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus_a.lfsr_state !== 4'd1) begin failures++; $display("FAIL reset_state got=%0d exp=1", bus_a.lfsr_state); end
        checks++; if (bus_a.value !== 4'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", bus_a.value); end
        checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_a.valid); end
        checks++; if (bus_a.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus_a.ready); end
        checks++; if (bus_b.lfsr_state !== 4'd1) begin failures++; $display("FAIL reset_state_b got=%0d exp=1", bus_b.lfsr_state); end
    endtask

    task automatic test_free_run();
        int exp_seq [16] = '{1, 3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8, 1};
        bus_a.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus_a.lfsr_state !== 4'(exp_seq[i])) begin
                failures++;
                $display("FAIL free_run[%0d] got=%0d exp=%0d", i, bus_a.lfsr_state, exp_seq[i]);
            end
            if (i < 15) @(negedge clk);
        end
        bus_a.en = 1'b0;
        @(negedge clk);
        checks++; if (bus_a.lfsr_state !== 4'd1) begin failures++; $display("FAIL hold_en0 got=%0d exp=1", bus_a.lfsr_state); end
    endtask

    task automatic test_draw_reject();
        int cyc; logic [3:0] v; bit rb, vr;
        load_seed(1'b0, 4'd15);
        checks++; if (bus_a.lfsr_state !== 4'd15) begin failures++; $display("FAIL seed15 got=%0d exp=15", bus_a.lfsr_state); end
        draw(1'b0, cyc, v, rb, vr);
        checks++; if (cyc !== 5) begin failures++; $display("FAIL draw_latency got=%0d exp=5", cyc); end
        checks++; if (v !== 4'd5) begin failures++; $display("FAIL draw_value got=%0d exp=5", v); end
        checks++; if (rb !== 1'b0) begin failures++; $display("FAIL draw_ready_low got=%b exp=0", rb); end
        checks++; if (vr !== 1'b1) begin failures++; $display("FAIL valid_cycle_ready got=%b exp=1", vr); end
        @(negedge clk);
        checks++; if (bus_a.valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b exp=0", bus_a.valid); end
        checks++; if (bus_a.value !== 4'd5) begin failures++; $display("FAIL value_hold got=%0d exp=5", bus_a.value); end
    endtask

    task automatic test_seed_zero_lockup();
        load_seed(1'b0, 4'd0);
        checks++; if (bus_a.lfsr_state !== 4'd1) begin failures++; $display("FAIL seed_zero got=%0d exp=1", bus_a.lfsr_state); end
        force dut_a.lfsr_q = 4'd0;
        #1;
        release dut_a.lfsr_q;
        bus_a.en = 1'b1;
        @(negedge clk);
        bus_a.en = 1'b0;
        checks++; if (bus_a.lfsr_state !== 4'd1) begin failures++; $display("FAIL lockup_recover got=%0d exp=1", bus_a.lfsr_state); end
    endtask

    task automatic test_fallback();
        int cyc; logic [3:0] v; bit rb, vr;
        load_seed(1'b1, 4'd4);
        draw(1'b1, cyc, v, rb, vr);
        checks++; if (v !== 4'd4) begin failures++; $display("FAIL fb_prime4 got=%0d exp=4", v); end
        load_seed(1'b1, 4'd15);
        draw(1'b1, cyc, v, rb, vr);
        checks++; if (v !== 4'd5) begin failures++; $display("FAIL fb_prev4 got=%0d exp=5", v); end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL fb_latency got=%0d exp=2", cyc); end
        load_seed(1'b1, 4'd8);
        draw(1'b1, cyc, v, rb, vr);
        checks++; if (v !== 4'd8) begin failures++; $display("FAIL fb_prime8 got=%0d exp=8", v); end
        load_seed(1'b1, 4'd15);
        draw(1'b1, cyc, v, rb, vr);
        checks++; if (v !== 4'd0) begin failures++; $display("FAIL fb_wrap got=%0d exp=0", v); end
    endtask

    task automatic test_no_repeat();
        int cyc; logic [3:0] v; bit rb, vr;
        load_seed(1'b0, 4'd3);
        draw(1'b0, cyc, v, rb, vr);
        checks++; if (v !== 4'd3) begin failures++; $display("FAIL nr_first got=%0d exp=3", v); end
        load_seed(1'b0, 4'd3);
        draw(1'b0, cyc, v, rb, vr);
`ifdef RAND_NO_REPEAT_EN
        checks++; if (v !== 4'd7) begin failures++; $display("FAIL nr_second got=%0d exp=7", v); end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL nr_latency got=%0d exp=2", cyc); end
`else
        checks++; if (v !== 4'd3) begin failures++; $display("FAIL rep_second got=%0d exp=3", v); end
        checks++; if (cyc !== 1) begin failures++; $display("FAIL rep_latency got=%0d exp=1", cyc); end
`endif
    endtask

    task automatic test_reset_mid_draw();
        bit seen_valid;
        load_seed(1'b0, 4'd15);
        bus_a.req = 1'b1;
        @(negedge clk);
        bus_a.req = 1'b0;
        @(negedge clk);
        checks++; if (bus_a.ready !== 1'b0) begin failures++; $display("FAIL mid_draw_ready got=%b exp=0", bus_a.ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.ready !== 1'b1) begin failures++; $display("FAIL rst_abort_ready got=%b exp=1", bus_a.ready); end
        checks++; if (bus_a.lfsr_state !== 4'd1) begin failures++; $display("FAIL rst_abort_state got=%0d exp=1", bus_a.lfsr_state); end
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_a.valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL rst_abort_valid got=%b exp=0", seen_valid); end
    endtask

    task automatic test_back_to_back();
        int exp_vals [6] = '{1, 3, 7, 5, 6, 2};
        int n = 0, consec = 0, not_ready = 0;
        logic last_valid = 1'b0;
        logic [3:0] got [6];
        bus_a.req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.valid) begin
                if (last_valid) consec++;
                if (!bus_a.ready) not_ready++;
                if (n < 6) got[n] = bus_a.value;
                n++;
            end
            last_valid = bus_a.valid;
        end
        bus_a.req = 1'b0;
        checks++; if (consec !== 0) begin failures++; $display("FAIL b2b_consecutive got=%0d exp=0", consec); end
        checks++; if (not_ready !== 0) begin failures++; $display("FAIL b2b_ready got=%0d exp=0", not_ready); end
        checks++; if (n < 6) begin failures++; $display("FAIL b2b_count got=%0d exp>=6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < n && got[i] !== 4'(exp_vals[i])) begin
                failures++;
                $display("FAIL b2b_value[%0d] got=%0d exp=%0d", i, got[i], exp_vals[i]);
            end
        end
    endtask

    initial begin
        bus_a.en = 1'b0; bus_a.seed_load = 1'b0; bus_a.seed_in = 4'd0; bus_a.req = 1'b0;
        bus_b.en = 1'b0; bus_b.seed_load = 1'b0; bus_b.seed_in = 4'd0; bus_b.req = 1'b0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_draw_reject();
        test_seed_zero_lockup();
        test_fallback();
        test_no_repeat();
        test_reset_mid_draw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
